// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential restoring divider
package div_pkg;

  // Controller states of the iterative divider
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Default divisor/remainder width; dividend and quotient are twice this
  localparam int DIV_N = 16;

  // Width of the step counter for an n-bit divisor (2n steps)
  function automatic int div_cnt_w(input int n);
    return $clog2(2 * n);
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_N);

  // Quotient reported for a zero divisor; sliced to 2N bits by the user
  localparam logic [63:0] DIV_DBZ_ALL_ONES = '1;

endpackage

// File: rtl/div_csel_add.sv
// rtl/div_csel_add.sv - carry-select adder cell, ripple of fixed-size select blocks
module div_csel_add #(
  parameter int W   = 17,
  parameter int BLK = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NB = (W + BLK - 1) / BLK;

  logic [NB:0] carry;

  assign carry[0] = cin;

  // Each block precomputes both carry-in cases; the incoming carry picks one.
  // The last block may be narrower when W is not a multiple of BLK.
  for (genvar i = 0; i < NB; i++) begin : g_blk
    localparam int LO = i * BLK;
    localparam int BW = ((W - LO) < BLK) ? (W - LO) : BLK;

    logic [BW:0] s0;
    logic [BW:0] s1;

    assign s0 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]};
    assign s1 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]} + {{BW{1'b0}}, 1'b1};

    assign sum[LO +: BW] = carry[i] ? s1[BW-1:0] : s0[BW-1:0];
    assign carry[i+1]    = carry[i] ? s1[BW]     : s0[BW];
  end

  assign cout = carry[NB];

endmodule

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] r,
  input  logic         bit_in,
  input  logic [N-1:0] d,
  output logic [N-1:0] r_next,
  output logic         q_bit
);

  logic [N:0] t;
  logic [N:0] diff;
  logic       no_borrow;
  logic       msb_unused;

  assign t = {r, bit_in};

  // T - D as T + ~{0,D} + 1; a carry out means no borrow, i.e. T >= D
  div_csel_add #(
    .W   (N + 1),
    .BLK (4)
  ) u_sub (
    .a    (t),
    .b    (~{1'b0, d}),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  // The kept remainder is always below D, so its top bit is always zero
  assign msb_unused = diff[N] ^ t[N];

  // Restore (keep T) when the subtract would go negative
  always_comb begin
    q_bit  = no_borrow;
    r_next = no_borrow ? diff[N-1:0] : t[N-1:0];
  end

endmodule

// File: rtl/seq_divider32by16.sv
// rtl/seq_divider32by16.sv - iterative 2N/N unsigned restoring divider with valid/ready
module seq_divider32by16
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int                 CNT_W        = div_cnt_w(N);
  localparam logic [CNT_W-1:0]   LAST_STEP    = CNT_W'(2 * N - 1);
  localparam logic [2*N-1:0]     DBZ_QUOTIENT = DIV_DBZ_ALL_ONES[2*N-1:0];

  div_state_e     state;
  logic [2*N-1:0] q_reg;
  logic [N-1:0]   d_reg;
  logic [N-1:0]   r_reg;
  logic [CNT_W-1:0] cnt;

  logic [N-1:0]   r_next;
  logic           q_bit;
  logic [2*N-1:0] q_next;

  // Partial remainder kept N bits wide: it never reaches D, so bit N stays zero
  div_step #(
    .N (N)
  ) u_step (
    .r      (r_reg),
    .bit_in (q_reg[2*N-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign q_next = {q_reg[2*N-2:0], q_bit};

  // Controller and datapath registers; all handshake and result outputs are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg    <= dividend;
            d_reg    <= divisor;
            r_reg    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= DBZ_QUOTIENT;
              remainder   <= dividend[N-1:0];
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
            end else begin
              state       <= BUSY;
              div_by_zero <= 1'b0;
            end
          end
        end
        BUSY: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            state     <= DONE;
            quotient  <= q_next;
            remainder <= r_next;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider32by16.sv
// tb/tb_seq_divider32by16.sv - randomized self-checking bench for seq_divider32by16
module tb_seq_divider32by16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_pass;
  int n_chk;

  seq_divider32by16 #(.N(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer division, with the zero-divisor convention
  function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic z);
    if (b == 16'd0) begin
      q = 32'hFFFF_FFFF;
      r = a[15:0];
      z = 1'b1;
    end else begin
      q = a / {16'd0, b};
      r = 16'(a % {16'd0, b});
      z = 1'b0;
    end
  endfunction

  // Issue one operation, scramble inputs while it runs, hold the result
  // for 'hold' cycles with out_ready low, then release it
  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int hold,
                        output logic [31:0] q, output logic [15:0] r,
                        output logic z, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_wait", 64'd0, 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = $urandom;
      divisor  = 16'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    for (int i = 0; i < hold; i++) begin
      dividend = $urandom;
      divisor  = 16'($urandom);
      @(negedge clk);
      chk("hold_stable", {in_ready, out_valid, quotient, remainder, div_by_zero},
          {1'b0, 1'b1, q, r, z});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [15:0] b,
                          input int hold, input int exp_lat);
    logic [31:0] q, eq;
    logic [15:0] r, er;
    logic        z, ez;
    int          lat;
    ref_div(a, b, eq, er, ez);
    run_op(a, b, hold, q, r, z, lat);
    chk({tag, "_q"},   {32'd0, q}, {32'd0, eq});
    chk({tag, "_r"},   {48'd0, r}, {48'd0, er});
    chk({tag, "_dbz"}, {63'd0, z}, {63'd0, ez});
    chk({tag, "_lat"}, 64'(lat),   64'(exp_lat));
  endtask

  initial begin
    logic [31:0] a, q, eq;
    logic [15:0] b, r, er;
    logic        z, ez;
    logic [63:0] recon;
    int          lat;
    int          sel;

    n_pass    = 0;
    n_chk     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {in_ready, out_valid, quotient, remainder, div_by_zero},
        {1'b1, 1'b0, 32'd0, 16'd0, 1'b0});
    rst = 1'b0;
    @(negedge clk);

    directed("square",   32'hFFFE_0001, 16'hFFFF, 0, 33);
    directed("100div7",  32'd100,       16'd7,    1, 33);
    directed("5div9",    32'd5,         16'd9,    0, 33);
    directed("divzero",  32'h1234_5678, 16'd0,    0, 1);
    directed("zero_dvd", 32'd0,         16'h1234, 0, 33);
    directed("backpres", 32'hDEAD_BEEF, 16'h1234, 20, 33);

    // Reset in the middle of a long operation drops it with no output
    in_valid = 1'b1;
    dividend = 32'hFFFF_FFFF;
    divisor  = 16'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_reset", {in_ready, out_valid, quotient, remainder, div_by_zero},
        {1'b1, 1'b0, 32'd0, 16'd0, 1'b0});
    directed("after_rst", 32'hFFFF_FFFF, 16'd3, 0, 33);

    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = 16'($urandom >> $urandom_range(0, 16));
      if (sel == 0) b = 16'd0;
      else if (sel == 1) a = a >> $urandom_range(16, 31);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ref_div(a, b, eq, er, ez);
      run_op(a, b, $urandom_range(0, 3), q, r, z, lat);
      chk("rnd_q",   {32'd0, q}, {32'd0, eq});
      chk("rnd_r",   {48'd0, r}, {48'd0, er});
      chk("rnd_dbz", {63'd0, z}, {63'd0, ez});
      if (b != 16'd0) begin
        recon = 64'(q) * 64'(b) + 64'(r);
        chk("rnd_invariant", recon, 64'(a));
        chk("rnd_rem_lt", {63'd0, r < b}, 64'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
